// File: rtl/entrada_operandos_ula_if.sv
// Switch/button inputs and registered ULA operand outputs of the operand-entry controller.
// The slave modport is the controller's view; the master modport is the board/bench view.
interface entrada_operandos_ula_if;
  logic [3:0] SW_dado;
  logic       SW_cin;
  logic       BTN_confirma_n;
  logic       BTN_cancela_n;
  logic [3:0] A_out;
  logic [3:0] B_out;
  logic       Cin_out;
  logic [2:0] OP_out;
  logic       op_valida;
  logic [1:0] etapa;
  logic       LED_erro_op;

  modport slave (
    input  SW_dado, SW_cin, BTN_confirma_n, BTN_cancela_n,
    output A_out, B_out, Cin_out, OP_out, op_valida, etapa, LED_erro_op
  );

  modport master (
    output SW_dado, SW_cin, BTN_confirma_n, BTN_cancela_n,
    input  A_out, B_out, Cin_out, OP_out, op_valida, etapa, LED_erro_op
  );
endinterface

// File: rtl/entrada_operandos_ula.sv
// Operand-entry controller for the 4-bit ULA: debounced confirm/cancel buttons step
// through A, B/Cin and op code, holding the registered set stable for the ULA.
module entrada_operandos_ula #(
  parameter int DEBOUNCE_CICLOS = 500000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  entrada_operandos_ula_if.slave bus
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_CICLOS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CICLOS - 1);

  typedef enum logic [1:0] {
    E_A      = 2'b00,
    E_B      = 2'b01,
    E_OP     = 2'b10,
    E_PRONTO = 2'b11
  } etapa_t;

  // Bit 0 is the confirm button, bit 1 the cancel button; both share one path.
  logic [1:0]       btn_raw;
  logic [1:0]       sync_p0;
  logic [1:0]       sync_p1;
  logic [1:0]       st_p2;
  logic [1:0]       st_d_p2;
  logic [CNT_W-1:0] cnt_p2 [2];
  logic [1:0]       pulse_p3;

  logic             conf;
  logic             canc;

  etapa_t           estado;
  etapa_t           estado_next;
  logic             ld_a;
  logic             ld_b;
  logic             ld_op;
  logic             erro_next;

  logic [3:0]       a_p4;
  logic [3:0]       b_p4;
  logic             cin_p4;
  logic [2:0]       op_p4;
  logic             vld_p4;
  logic             erro_p4;

  assign btn_raw = {bus.BTN_cancela_n, bus.BTN_confirma_n};

  // Stage p0/p1: two-flop synchronizer. Stage p2: stable level with run-length counter.
  // Stage p3: press pulse from the registered 1->0 transition of the stable level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p0   <= 2'b11;
      sync_p1   <= 2'b11;
      st_p2     <= 2'b11;
      st_d_p2   <= 2'b11;
      pulse_p3  <= 2'b00;
      cnt_p2[0] <= '0;
      cnt_p2[1] <= '0;
    end else begin
      sync_p0  <= btn_raw;
      sync_p1  <= sync_p0;
      st_d_p2  <= st_p2;
      pulse_p3 <= st_d_p2 & ~st_p2;
      for (int i = 0; i < 2; i++) begin
        if (sync_p1[i] == st_p2[i]) begin
          cnt_p2[i] <= '0;
        end else if (cnt_p2[i] == CNT_MAX) begin
          st_p2[i]  <= sync_p1[i];
          cnt_p2[i] <= '0;
        end else begin
          cnt_p2[i] <= cnt_p2[i] + CNT_W'(1);
        end
      end
    end
  end

  assign conf = pulse_p3[0];
  assign canc = pulse_p3[1];

  // Stage p4: entry FSM and the operand registers it loads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado <= E_A;
    end else begin
      estado <= estado_next;
    end
  end

  always_comb begin
    estado_next = estado;
    ld_a        = 1'b0;
    ld_b        = 1'b0;
    ld_op       = 1'b0;
    erro_next   = erro_p4;
    if (canc) begin
      // Cancel dominates a coincident confirm, which is simply dropped.
      estado_next = E_A;
      erro_next   = 1'b0;
    end else if (conf) begin
      unique case (estado)
        E_A: begin
          ld_a        = 1'b1;
          estado_next = E_B;
        end
        E_B: begin
          ld_b        = 1'b1;
          estado_next = E_OP;
        end
        E_OP: begin
          if (bus.SW_dado[2:0] == 3'b111) begin
            erro_next = 1'b1;
          end else begin
            ld_op       = 1'b1;
            erro_next   = 1'b0;
            estado_next = E_PRONTO;
          end
        end
        E_PRONTO: begin
          estado_next = E_A;
        end
        default: estado_next = E_A;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_p4    <= '0;
      b_p4    <= '0;
      cin_p4  <= 1'b0;
      op_p4   <= '0;
      vld_p4  <= 1'b0;
      erro_p4 <= 1'b0;
    end else begin
      if (ld_a) begin
        a_p4 <= bus.SW_dado;
      end
      if (ld_b) begin
        b_p4   <= bus.SW_dado;
        cin_p4 <= bus.SW_cin;
      end
      if (ld_op) begin
        op_p4 <= bus.SW_dado[2:0];
      end
      vld_p4  <= (estado_next == E_PRONTO);
      erro_p4 <= erro_next;
    end
  end

  assign bus.A_out       = a_p4;
  assign bus.B_out       = b_p4;
  assign bus.Cin_out     = cin_p4;
  assign bus.OP_out      = op_p4;
  assign bus.op_valida   = vld_p4;
  assign bus.etapa       = estado;
  assign bus.LED_erro_op = erro_p4;

endmodule
